lc4_alu_arbiter: RTL and testbench

Shares a single `lc4_alu` instance between two requesters, e.g. two pipeline threads or a pipeline and a debug/trace unit, using round-robin arbitration and valid/ready handshakes on both the request and response sides. Each accepted operation is evaluated combinationally in the embedded ALU and captured into a per-requester response register. The block also keeps per-requester saturating grant counters for performance statistics.

---
 rtl/lc4_alu_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_lc4_alu_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lc4_alu_arbiter.sv
// lc4_alu: combinational LC4 ALU. Produces the arithmetic/logic result,
// the effective address for LDR/STR, or the control-transfer target for
// BR/JMP/JMPR/JSR/JSRR/RTI/TRAP.
// Ports:
//   insn     - 16-bit LC4 instruction
//   pc       - PC of the instruction
//   r1data   - rs operand (destination register value for HICONST)
//   r2data   - rt operand
//   result_c - combinational result; 0 for unused opcodes
//
// lc4_alu_arbiter: round-robin arbiter sharing one lc4_alu between two
// requesters with valid/ready handshakes on request and response sides.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   reqN_valid / reqN_ready  - request handshake (ready is combinational)
//   reqN_insn/pc/r1data/r2data - request operands
//   rspN_valid / rspN_ready  - response handshake
//   rspN_result              - registered ALU result
//   grant_countN             - saturating count of accepted operations

module lc4_alu (
    input  logic [15:0] insn,
    input  logic [15:0] pc,
    input  logic [15:0] r1data,
    input  logic [15:0] r2data,
    output logic [15:0] result_c
);
    localparam int unsigned W = 16;

    logic [W-1:0] imm5, imm6, imm7, uimm7, imm9, imm11;
    logic [W-1:0] pc_inc;
    logic [W-1:0] cmp_b;
    logic         cmp_lt, cmp_eq;

    assign imm5   = {{11{insn[4]}}, insn[4:0]};
    assign imm6   = {{10{insn[5]}}, insn[5:0]};
    assign imm7   = {{9{insn[6]}}, insn[6:0]};
    assign uimm7  = {9'b0, insn[6:0]};
    assign imm9   = {{7{insn[8]}}, insn[8:0]};
    assign imm11  = {{5{insn[10]}}, insn[10:0]};
    assign pc_inc = pc + W'(1);

    // Compare family: subop selects rt / imm7 / uimm7 and signedness
    always_comb begin
        cmp_b = r2data;
        if (insn[8]) begin
            cmp_b = insn[7] ? uimm7 : imm7;
        end
        cmp_eq = (r1data == cmp_b);
        if (insn[7]) begin
            cmp_lt = (r1data < cmp_b);
        end else begin
            cmp_lt = ($signed(r1data) < $signed(cmp_b));
        end
    end

    // Opcode decode
    always_comb begin
        result_c = '0;
        case (insn[15:12])
            4'b0000: result_c = pc_inc + imm9;
            4'b0001: begin
                if (insn[5]) begin
                    result_c = r1data + imm5;
                end else begin
                    case (insn[4:3])
                        2'b00:   result_c = r1data + r2data;
                        2'b01:   result_c = W'(r1data * r2data);
                        2'b10:   result_c = r1data - r2data;
                        default: result_c = (r2data == '0) ? '0 : r1data / r2data;
                    endcase
                end
            end
            4'b0010: result_c = cmp_eq ? W'(0) : (cmp_lt ? W'(16'hFFFF) : W'(1));
            4'b0100: result_c = insn[11] ? ((pc & 16'h8000) | {1'b0, insn[10:0], 4'b0000})
                                         : r1data;
            4'b0101: begin
                if (insn[5]) begin
                    result_c = r1data & imm5;
                end else begin
                    case (insn[4:3])
                        2'b00:   result_c = r1data & r2data;
                        2'b01:   result_c = ~r1data;
                        2'b10:   result_c = r1data | r2data;
                        default: result_c = r1data ^ r2data;
                    endcase
                end
            end
            4'b0110, 4'b0111: result_c = r1data + imm6;
            4'b1000: result_c = r1data;
            4'b1001: result_c = imm9;
            4'b1010: begin
                case (insn[5:4])
                    2'b00:   result_c = r1data << insn[3:0];
                    2'b01:   result_c = W'($signed(r1data) >>> insn[3:0]);
                    2'b10:   result_c = r1data >> insn[3:0];
                    default: result_c = (r2data == '0) ? '0 : r1data % r2data;
                endcase
            end
            4'b1100: result_c = insn[11] ? (pc_inc + imm11) : r1data;
            4'b1101: result_c = {insn[7:0], r1data[7:0]};
            4'b1111: result_c = {8'h80, insn[7:0]};
            default: result_c = '0;
        endcase
    end
endmodule

module lc4_alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_insn,
    input  logic [15:0] req0_pc,
    input  logic [15:0] req0_r1data,
    input  logic [15:0] req0_r2data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_insn,
    input  logic [15:0] req1_pc,
    input  logic [15:0] req1_r1data,
    input  logic [15:0] req1_r2data,
    output logic        rsp0_valid,
    output logic [15:0] rsp0_result,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    output logic [15:0] rsp1_result,
    input  logic        rsp1_ready,
    output logic [15:0] grant_count0,
    output logic [15:0] grant_count1
);
    localparam int unsigned W = 16;
    localparam logic [W-1:0] CNT_MAX = 16'hFFFF;

    logic         elig0, elig1;
    logic         grant0, grant1;
    logic         last_grant;
    logic [W-1:0] alu_insn, alu_pc, alu_r1, alu_r2, alu_result;

    // A slot is eligible when empty or drained this same cycle
    assign elig0 = req0_valid && (!rsp0_valid || rsp0_ready);
    assign elig1 = req1_valid && (!rsp1_valid || rsp1_ready);

    // Round-robin: on contention the requester not granted last wins
    assign grant0 = elig0 && (!elig1 || last_grant);
    assign grant1 = elig1 && (!elig0 || !last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Requester 0 drives the ALU when idle; the result is then discarded
    always_comb begin
        alu_insn = req0_insn;
        alu_pc   = req0_pc;
        alu_r1   = req0_r1data;
        alu_r2   = req0_r2data;
        if (grant1) begin
            alu_insn = req1_insn;
            alu_pc   = req1_pc;
            alu_r1   = req1_r1data;
            alu_r2   = req1_r2data;
        end
    end

    lc4_alu u_alu (
        .insn     (alu_insn),
        .pc       (alu_pc),
        .r1data   (alu_r1),
        .r2data   (alu_r2),
        .result_c (alu_result)
    );

    // Response slot and counter for requester 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid   <= 1'b0;
            rsp0_result  <= '0;
            grant_count0 <= '0;
        end else if (grant0) begin
            rsp0_valid   <= 1'b1;
            rsp0_result  <= alu_result;
            if (grant_count0 != CNT_MAX) begin
                grant_count0 <= grant_count0 + W'(1);
            end
        end else if (rsp0_valid && rsp0_ready) begin
            rsp0_valid <= 1'b0;
        end
    end

    // Response slot and counter for requester 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp1_valid   <= 1'b0;
            rsp1_result  <= '0;
            grant_count1 <= '0;
        end else if (grant1) begin
            rsp1_valid   <= 1'b1;
            rsp1_result  <= alu_result;
            if (grant_count1 != CNT_MAX) begin
                grant_count1 <= grant_count1 + W'(1);
            end
        end else if (rsp1_valid && rsp1_ready) begin
            rsp1_valid <= 1'b0;
        end
    end

    // Reset to 1 so requester 0 wins the first contended cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lc4_alu_arbiter.sv
// Testbench for lc4_alu_arbiter: table of single-op ALU vectors on
// requester 0, plus directed sequences for reset, contention,
// backpressure, back-to-back issue and counter saturation.
module tb_lc4_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_insn, req0_pc, req0_r1data, req0_r2data;
    logic [15:0] req1_insn, req1_pc, req1_r1data, req1_r2data;
    logic        rsp0_valid, rsp1_valid;
    logic [15:0] rsp0_result, rsp1_result;
    logic        rsp0_ready, rsp1_ready;
    logic [15:0] grant_count0, grant_count1;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] insn;
        logic [15:0] pc;
        logic [15:0] r1;
        logic [15:0] r2;
        logic [15:0] exp;
    } vec_t;

    localparam int NV = 28;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    lc4_alu_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_insn    (req0_insn),
        .req0_pc      (req0_pc),
        .req0_r1data  (req0_r1data),
        .req0_r2data  (req0_r2data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_insn    (req1_insn),
        .req1_pc      (req1_pc),
        .req1_r1data  (req1_r1data),
        .req1_r2data  (req1_r2data),
        .rsp0_valid   (rsp0_valid),
        .rsp0_result  (rsp0_result),
        .rsp0_ready   (rsp0_ready),
        .rsp1_valid   (rsp1_valid),
        .rsp1_result  (rsp1_result),
        .rsp1_ready   (rsp1_ready),
        .grant_count0 (grant_count0),
        .grant_count1 (grant_count1)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req0(input logic [15:0] insn, input logic [15:0] pc,
                            input logic [15:0] r1, input logic [15:0] r2);
        req0_insn = insn; req0_pc = pc; req0_r1data = r1; req0_r2data = r2;
    endtask

    task automatic set_req1(input logic [15:0] insn, input logic [15:0] pc,
                            input logic [15:0] r1, input logic [15:0] r2);
        req1_insn = insn; req1_pc = pc; req1_r1data = r1; req1_r2data = r2;
    endtask

    // Returns at 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // insn, pc, r1, r2, expected result
        vecs[0]  = '{16'h1042, 16'h0000, 16'h0003, 16'h0004, 16'h0007}; // ADD
        vecs[1]  = '{16'h104A, 16'h0000, 16'h0006, 16'h0007, 16'h002A}; // MUL
        vecs[2]  = '{16'h1052, 16'h0000, 16'h0009, 16'h0004, 16'h0005}; // SUB
        vecs[3]  = '{16'h105A, 16'h0000, 16'h0064, 16'h0007, 16'h000E}; // DIV
        vecs[4]  = '{16'h105A, 16'h0000, 16'h0005, 16'h0000, 16'h0000}; // DIV /0
        vecs[5]  = '{16'h107F, 16'h0000, 16'h0010, 16'h0000, 16'h000F}; // ADD imm -1
        vecs[6]  = '{16'h2002, 16'h0000, 16'hFFFF, 16'h0001, 16'hFFFF}; // CMP
        vecs[7]  = '{16'h2082, 16'h0000, 16'hFFFF, 16'h0001, 16'h0001}; // CMPU
        vecs[8]  = '{16'h2105, 16'h0000, 16'h0005, 16'h0000, 16'h0000}; // CMPI eq
        vecs[9]  = '{16'h5042, 16'h0000, 16'h0F0F, 16'h00FF, 16'h000F}; // AND
        vecs[10] = '{16'h504A, 16'h0000, 16'h0F0F, 16'h00FF, 16'hF0F0}; // NOT
        vecs[11] = '{16'h5052, 16'h0000, 16'h0F0F, 16'h00FF, 16'h0FFF}; // OR
        vecs[12] = '{16'h505A, 16'h0000, 16'h0F0F, 16'h00FF, 16'h0FF0}; // XOR
        vecs[13] = '{16'h5065, 16'h0000, 16'h0F0F, 16'h0000, 16'h0005}; // AND imm
        vecs[14] = '{16'h607F, 16'h0000, 16'h2000, 16'h0000, 16'h1FFF}; // LDR -1
        vecs[15] = '{16'h9105, 16'h0000, 16'h0000, 16'h0000, 16'hFF05}; // CONST
        vecs[16] = '{16'hA044, 16'h0000, 16'h0003, 16'h0000, 16'h0030}; // SLL 4
        vecs[17] = '{16'hA054, 16'h0000, 16'h8000, 16'h0000, 16'hF800}; // SRA 4
        vecs[18] = '{16'hA064, 16'h0000, 16'h8000, 16'h0000, 16'h0800}; // SRL 4
        vecs[19] = '{16'hA072, 16'h0000, 16'h0064, 16'h0007, 16'h0002}; // remainder
        vecs[20] = '{16'h0E05, 16'h0100, 16'h0000, 16'h0000, 16'h0106}; // BR +5
        vecs[21] = '{16'hD1AB, 16'h0000, 16'h1234, 16'h0000, 16'hAB34}; // HICONST
        vecs[22] = '{16'hF025, 16'h0000, 16'h0000, 16'h0000, 16'h8025}; // TRAP
        vecs[23] = '{16'hCFFF, 16'h0100, 16'h0000, 16'h0000, 16'h0100}; // JMP -1
        vecs[24] = '{16'hC040, 16'h0000, 16'h4321, 16'h0000, 16'h4321}; // JMPR
        vecs[25] = '{16'h4801, 16'h8123, 16'h0000, 16'h0000, 16'h8010}; // JSR
        vecs[26] = '{16'h4040, 16'h0000, 16'h1111, 16'h0000, 16'h1111}; // JSRR
        vecs[27] = '{16'h8000, 16'h0000, 16'h3333, 16'h0000, 16'h3333}; // RTI

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        set_req0(16'h0, 16'h0, 16'h0, 16'h0);
        set_req1(16'h0, 16'h0, 16'h0, 16'h0);
        tick(); tick();
        chk("reset_rsp0_valid", 16'(rsp0_valid), 16'h0);
        chk("reset_rsp1_valid", 16'(rsp1_valid), 16'h0);
        chk("reset_req0_ready", 16'(req0_ready), 16'h0);
        chk("reset_cnt0", grant_count0, 16'h0);
        chk("reset_cnt1", grant_count1, 16'h0);
        rst = 1'b0;
        tick();

        // Single ADD on requester 0
        set_req0(16'h1042, 16'h0, 16'h0003, 16'h0004);
        req0_valid = 1'b1; rsp0_ready = 1'b1;
        #1 chk("add_req0_ready", 16'(req0_ready), 16'h1);
        chk("add_req1_ready", 16'(req1_ready), 16'h0);
        tick();
        req0_valid = 1'b0; rsp0_ready = 1'b0;
        chk("add_rsp0_valid", 16'(rsp0_valid), 16'h1);
        chk("add_rsp0_result", rsp0_result, 16'h0007);
        chk("add_cnt0", grant_count0, 16'h0001);

        // Async reset mid-cycle while a response is held
        tick();
        chk("hold_rsp0_valid", 16'(rsp0_valid), 16'h1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rsp0_valid", 16'(rsp0_valid), 16'h0);
        chk("midrst_rsp0_result", rsp0_result, 16'h0000);
        chk("midrst_cnt0", grant_count0, 16'h0000);
        tick();
        rst = 1'b0;

        // Contention: grants alternate 0,1,0,1
        set_req0(16'h1042, 16'h0, 16'h0001, 16'h0002);
        set_req1(16'h1052, 16'h0, 16'h0009, 16'h0004);
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("cont%0d_req0_ready", c), 16'(req0_ready), 16'((c % 2) == 0));
            chk($sformatf("cont%0d_req1_ready", c), 16'(req1_ready), 16'((c % 2) == 1));
            tick();
            if ((c % 2) == 0) begin
                chk($sformatf("cont%0d_rsp0_valid", c), 16'(rsp0_valid), 16'h1);
                chk($sformatf("cont%0d_rsp0_result", c), rsp0_result, 16'h0003);
                chk($sformatf("cont%0d_rsp1_valid", c), 16'(rsp1_valid), 16'h0);
            end else begin
                chk($sformatf("cont%0d_rsp1_valid", c), 16'(rsp1_valid), 16'h1);
                chk($sformatf("cont%0d_rsp1_result", c), rsp1_result, 16'h0005);
                chk($sformatf("cont%0d_rsp0_valid", c), 16'(rsp0_valid), 16'h0);
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_cnt0", grant_count0, 16'h0002);
        chk("cont_cnt1", grant_count1, 16'h0002);
        tick();

        // Table of ALU vectors on requester 0
        for (int i = 0; i < NV; i++) begin
            set_req0(vecs[i].insn, vecs[i].pc, vecs[i].r1, vecs[i].r2);
            req0_valid = 1'b1; rsp0_ready = 1'b1;
            #1 chk($sformatf("vec%0d_ready", i), 16'(req0_ready), 16'h1);
            tick();
            req0_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 16'(rsp0_valid), 16'h1);
            chk($sformatf("vec%0d_result", i), rsp0_result, vecs[i].exp);
        end
        tick();
        chk("vec_drained", 16'(rsp0_valid), 16'h0);

        // Backpressure on requester 0
        set_req0(16'h1042, 16'h0, 16'h0003, 16'h0004);
        req0_valid = 1'b1; rsp0_ready = 1'b0;
        tick();
        chk("bp_rsp0_valid", 16'(rsp0_valid), 16'h1);
        chk("bp_rsp0_result", rsp0_result, 16'h0007);
        set_req0(16'h1042, 16'h0, 16'h000A, 16'h000A);
        set_req1(16'h1042, 16'h0, 16'h0020, 16'h0001);
        req1_valid = 1'b1; rsp1_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_req0_ready", c), 16'(req0_ready), 16'h0);
            chk($sformatf("bp%0d_req1_ready", c), 16'(req1_ready), 16'h1);
            tick();
            chk($sformatf("bp%0d_rsp0_result", c), rsp0_result, 16'h0007);
            chk($sformatf("bp%0d_rsp0_valid", c), 16'(rsp0_valid), 16'h1);
            chk($sformatf("bp%0d_rsp1_result", c), rsp1_result, 16'h0021);
        end
        rsp0_ready = 1'b1;
        #1 chk("bp_release_req0_ready", 16'(req0_ready), 16'h1);
        chk("bp_release_req1_ready", 16'(req1_ready), 16'h0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("bp_release_result", rsp0_result, 16'h0014);
        tick();

        // Back-to-back on requester 1 from a clean state
        do_reset();
        rsp1_ready = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_req1(16'h1042, 16'h0, 16'(k), 16'h0064);
            #1 chk($sformatf("b2b%0d_req1_ready", k), 16'(req1_ready), 16'h1);
            tick();
            chk($sformatf("b2b%0d_rsp1_valid", k), 16'(rsp1_valid), 16'h1);
            chk($sformatf("b2b%0d_rsp1_result", k), rsp1_result, 16'(k + 100));
        end
        req1_valid = 1'b0;
        chk("b2b_cnt1", grant_count1, 16'h0005);
        tick();

        // Saturation: 65534 grants bring counter 0 to FFFE
        do_reset();
        set_req0(16'h1042, 16'h0, 16'h0001, 16'h0001);
        req0_valid = 1'b1; rsp0_ready = 1'b1;
        repeat (65534) @(posedge clk);
        #1 chk("sat_pre_cnt0", grant_count0, 16'hFFFE);
        for (int k = 0; k < 3; k++) begin
            set_req0(16'h1042, 16'h0, 16'(k + 16'h0050), 16'h0001);
            tick();
            chk($sformatf("sat%0d_cnt0", k), grant_count0, 16'hFFFF);
            chk($sformatf("sat%0d_result", k), rsp0_result, 16'(k + 16'h0051));
            chk($sformatf("sat%0d_valid", k), 16'(rsp0_valid), 16'h1);
        end
        req0_valid = 1'b0;
        chk("sat_cnt1", grant_count1, 16'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
